dll_lock_fsm: RTL and testbench

Sequential, parametrised successor to the DLL lock selector. It steers the delay-line UP/DOWN command between the false-lock detector (FLD) and the PFD using a hysteretic state machine. It raises a qualified lock flag and blanks outputs while the early-late inputs are invalid. It sits between the PFD/FLD front end and the DLL charge-pump/digital loop filter.

---
 rtl/dll_lock_pkg.sv | 17 +
 rtl/dll_lock_if.sv | 27 ++
 rtl/dll_run_cnt.sv | 32 +++
 rtl/dll_lock_fsm.sv | 141 ++++++++++++++
 tb/tb_dll_lock_fsm.sv | 131 +++++++++++++
 5 files changed

// File: rtl/dll_lock_pkg.sv
// Shared definitions for the DLL lock controller: state encoding and the
// default run-length thresholds used by dll_lock_fsm.
package dll_lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } dll_state_t;

    localparam int DEF_CNT_W      = 6;
    localparam int DEF_ACQ_CNT    = 16;
    localparam int DEF_UNLOCK_CNT = 4;
    localparam int DEF_LOCK_CNT   = 32;

endpackage

// File: rtl/dll_lock_if.sv
// Front-end / loop-side signal bundle of the DLL lock controller.
// master: PFD/FLD front end plus loop observer; slave: dll_lock_fsm.
interface dll_lock_if;

    logic       up_pfd_i;
    logic       down_pfd_i;
    logic       up_fld_i;
    logic       down_fld_i;
    logic       lock_fld_i;
    logic       el_validb_i;
    logic       up_o;
    logic       down_o;
    logic       pfd_sel_o;
    logic       lock_o;
    logic [1:0] state_o;

    modport master (
        output up_pfd_i, down_pfd_i, up_fld_i, down_fld_i, lock_fld_i, el_validb_i,
        input  up_o, down_o, pfd_sel_o, lock_o, state_o
    );

    modport slave (
        input  up_pfd_i, down_pfd_i, up_fld_i, down_fld_i, lock_fld_i, el_validb_i,
        output up_o, down_o, pfd_sel_o, lock_o, state_o
    );

endinterface

// File: rtl/dll_run_cnt.sv
// Saturating consecutive-run counter. hit_o flags the cycle whose sample
// completes a run of thr_i consecutive run_i cycles, so the caller can act
// on that same clock edge.
module dll_run_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rstb_i,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign hit_o   = run_i && (cnt_inc >= {1'b0, thr_i});

    // Count while the condition holds, hold at all-ones, drop to zero otherwise.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            cnt_q <= '0;
        end else if (clr_i || !run_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/dll_lock_fsm.sv
// DLL lock controller: steers the delay-line UP/DOWN command between the
// false-lock detector (ACQ) and the PFD (TRACK/LOCKED) with run-length
// hysteresis, and raises a qualified lock flag.
// Build option: DLL_LOCK_SYNC_EN adds a 2-flop synchronizer on every
// non-clock/reset input (latency 3 clocks instead of 1).
//
// state  | meaning
// IDLE   | early-late inputs invalid or just out of reset; outputs blanked
// ACQ    | FLD steering, waiting for ACQ_CNT in-window cycles
// TRACK  | PFD steering, waiting for LOCK_CNT in-window cycles
// LOCKED | PFD steering, lock_o asserted
module dll_lock_fsm
    import dll_lock_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ACQ_CNT    = DEF_ACQ_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
    input  logic     clk_i,
    input  logic     rstb_i,
    dll_lock_if.slave bus
);

    localparam logic [CNT_W-1:0] ACQ_THR    = CNT_W'(ACQ_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_THR = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] LOCK_THR   = CNT_W'(LOCK_CNT);

    logic [5:0] in_raw, in_s;
    logic       up_pfd, down_pfd, up_fld, down_fld, lock_fld, el_validb;

    assign in_raw = {bus.up_pfd_i, bus.down_pfd_i, bus.up_fld_i,
                     bus.down_fld_i, bus.lock_fld_i, bus.el_validb_i};

`ifdef DLL_LOCK_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    // Two-stage resynchronisation of the front-end inputs into clk_i.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in_raw;
`endif

    assign {up_pfd, down_pfd, up_fld, down_fld, lock_fld, el_validb} = in_s;

    dll_state_t       state_q, state_nxt;
    logic             up_q, down_q, sel_q, lock_q;
    logic             up_nxt, down_nxt, sel_nxt, lock_nxt;
    logic             cnt_clr, hit_one, hit_zero;
    logic [CNT_W-1:0] one_thr;

    // The in-window counter serves both ACQ->TRACK and TRACK->LOCKED.
    assign one_thr = (state_q == ACQ) ? ACQ_THR : LOCK_THR;
    assign cnt_clr = (state_nxt != state_q) || el_validb;

    dll_run_cnt #(.CNT_W(CNT_W)) u_cnt_one (
        .clk_i  (clk_i),
        .rstb_i (rstb_i),
        .run_i  (lock_fld),
        .clr_i  (cnt_clr),
        .thr_i  (one_thr),
        .hit_o  (hit_one)
    );

    dll_run_cnt #(.CNT_W(CNT_W)) u_cnt_zero (
        .clk_i  (clk_i),
        .rstb_i (rstb_i),
        .run_i  (!lock_fld),
        .clr_i  (cnt_clr),
        .thr_i  (UNLOCK_THR),
        .hit_o  (hit_zero)
    );

    // Next state plus next registered outputs; steering follows the current
    // state, while pfd_sel/lock track the state being entered.
    always_comb begin
        state_nxt = state_q;
        up_nxt    = 1'b0;
        down_nxt  = 1'b0;
        if (el_validb) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE: state_nxt = ACQ;
                ACQ: begin
                    up_nxt   = up_fld & ~down_fld;
                    down_nxt = down_fld & ~up_fld;
                    if (hit_one) state_nxt = TRACK;
                end
                TRACK: begin
                    up_nxt   = up_pfd;
                    down_nxt = down_pfd;
                    if (hit_one)       state_nxt = LOCKED;
                    else if (hit_zero) state_nxt = ACQ;
                end
                LOCKED: begin
                    up_nxt   = up_pfd;
                    down_nxt = down_pfd;
                    if (hit_zero) state_nxt = ACQ;
                end
                default: state_nxt = IDLE;
            endcase
        end
        sel_nxt  = (state_nxt == TRACK) || (state_nxt == LOCKED);
        lock_nxt = (state_nxt == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            sel_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            up_q    <= up_nxt;
            down_q  <= down_nxt;
            sel_q   <= sel_nxt;
            lock_q  <= lock_nxt;
        end
    end

    assign bus.up_o      = up_q;
    assign bus.down_o    = down_q;
    assign bus.pfd_sel_o = sel_q;
    assign bus.lock_o    = lock_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_dll_lock_fsm.sv
// Directed bench for dll_lock_fsm (default build, default thresholds).
module tb_dll_lock_fsm;

    logic clk_i  = 1'b0;
    logic rstb_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dll_lock_if bus();

    dll_lock_fsm dut (
        .clk_i  (clk_i),
        .rstb_i (rstb_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic up,
                           input logic dn, input logic sel, input logic lk);
        chk({tag, ".state"}, bus.state_o, st);
        chk({tag, ".up"}, {1'b0, bus.up_o}, {1'b0, up});
        chk({tag, ".down"}, {1'b0, bus.down_o}, {1'b0, dn});
        chk({tag, ".sel"}, {1'b0, bus.pfd_sel_o}, {1'b0, sel});
        chk({tag, ".lock"}, {1'b0, bus.lock_o}, {1'b0, lk});
    endtask

    initial begin
        bus.up_pfd_i    = 1'b0;
        bus.down_pfd_i  = 1'b0;
        bus.up_fld_i    = 1'b1;
        bus.down_fld_i  = 1'b0;
        bus.lock_fld_i  = 1'b1;
        bus.el_validb_i = 1'b0;
        repeat (3) tick();
        chk_all("reset", 2'd0, 0, 0, 0, 0);

        // bring-up: IDLE -> ACQ -> TRACK (16) -> LOCKED (32)
        rstb_i = 1'b1;
        tick();
        chk_all("enter_acq", 2'd1, 0, 0, 0, 0);
        tick();
        chk_all("acq_up", 2'd1, 1, 0, 0, 0);
        repeat (14) tick();
        chk("acq_cnt15.state", bus.state_o, 2'd1);
        tick();
        chk_all("enter_track", 2'd2, 1, 0, 1, 0);
        bus.up_pfd_i   = 1'b1;
        bus.down_pfd_i = 1'b1;
        tick();
        chk_all("track_both", 2'd2, 1, 1, 1, 0);
        repeat (30) tick();
        chk_all("lock_cnt31", 2'd2, 1, 1, 1, 0);
        tick();
        chk_all("enter_locked", 2'd3, 1, 1, 1, 1);
        bus.down_pfd_i = 1'b0;
        bus.up_fld_i   = 1'b0;
        bus.down_fld_i = 1'b1;
        tick();
        chk_all("locked_pfd", 2'd3, 1, 0, 1, 1);

        // short lock_fld dropouts keep lock
        bus.lock_fld_i = 1'b0;
        repeat (3) tick();
        chk_all("glitch3", 2'd3, 1, 0, 1, 1);
        bus.lock_fld_i = 1'b1;
        tick();
        chk("glitch_end.state", bus.state_o, 2'd3);
        bus.lock_fld_i = 1'b0;
        repeat (3) tick();
        chk("unlock3.lock", {1'b0, bus.lock_o}, 2'd1);
        tick();
        chk("unlock4.state", bus.state_o, 2'd1);
        chk("unlock4.lock", {1'b0, bus.lock_o}, 2'd0);
        chk("unlock4.sel", {1'b0, bus.pfd_sel_o}, 2'd0);

        // FLD codes in ACQ
        bus.up_fld_i   = 1'b1;
        bus.down_fld_i = 1'b1;
        tick();
        chk_all("fld_illegal", 2'd1, 0, 0, 0, 0);
        bus.up_fld_i = 1'b0;
        tick();
        chk_all("fld_down", 2'd1, 0, 1, 0, 0);
        bus.lock_fld_i = 1'b1;
        repeat (15) tick();
        chk("reacq15.state", bus.state_o, 2'd1);
        tick();
        chk("reacq16.state", bus.state_o, 2'd2);

        // invalid early-late in TRACK forces IDLE, then restart from zero
        bus.el_validb_i = 1'b1;
        tick();
        chk_all("validb", 2'd0, 0, 0, 0, 0);
        bus.el_validb_i = 1'b0;
        tick();
        chk_all("validb_acq", 2'd1, 0, 0, 0, 0);
        repeat (15) tick();
        chk("restart15.state", bus.state_o, 2'd1);
        tick();
        chk("restart16.state", bus.state_o, 2'd2);
        chk("restart16.sel", {1'b0, bus.pfd_sel_o}, 2'd1);
        repeat (31) tick();
        chk("relock31.state", bus.state_o, 2'd2);
        tick();
        chk_all("relock32", 2'd3, 1, 0, 1, 1);

        // asynchronous reset between edges
        #2;
        rstb_i = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
